uart_tx: RTL and testbench

//  Serial UART transmitter, counterpart of the UART_RX block. Accepts one parallel byte per

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_cnt.sv | 39 +++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver.
// It holds the FSM state encoding and the line-level and parity-type constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts 0..prescale-1 and raises tick on the last clock of each bit period.
// A prescale of 0 is treated as 1, so tick is then high on every clock.
module uart_baud_cnt #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] last_s;

  // Terminal count value, saturating a zero prescale to one clock per bit
  always_comb begin
    last_s = {WIDTH{1'b0}};
    if (prescale != {WIDTH{1'b0}}) begin
      last_s = prescale - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      last_s = {WIDTH{1'b0}};
    end
  end

  assign tick = !clear && (cnt_r == last_s);

  // Count register, restarted by clear or by reaching the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (clear || tick) begin
      cnt_r <= {WIDTH{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, then stop.
// Each bit lasts prescale clocks; all frame settings are captured when the byte is accepted.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic par_typ);
    if (par_typ == PAR_ODD) begin
      parity_bit = ~^data;
    end else begin
      parity_bit = ^data;
    end
  endfunction

  uart_state_e               state_r, state_nxt;
  logic [IDX_W-1:0]          idx_r, idx_nxt;
  logic [DATA_WIDTH-1:0]     data_r;
  logic                      par_en_r;
  logic                      par_bit_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic                      tx_r, tx_nxt;
  logic                      busy_r, busy_nxt;
  logic                      accept_s;
  logic                      tick_s;

  uart_baud_cnt #(
    .WIDTH(PRESCALE_WIDTH)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_r == IDLE),
    .prescale(prescale_r),
    .tick    (tick_s)
  );

  // Next-state, bit index and next line level; the line level follows the upcoming state
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    tx_nxt    = tx_r;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (DATA_VALID) begin
          accept_s  = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_nxt = DATA;
          idx_nxt   = IDX_ZERO;
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (tick_s && (idx_r == IDX_LAST)) begin
          idx_nxt   = IDX_ZERO;
          state_nxt = par_en_r ? PARITY : STOP;
        end else if (tick_s) begin
          idx_nxt = idx_r + IDX_ONE;
        end else begin
          idx_nxt = idx_r;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_nxt = STOP;
        end else begin
          state_nxt = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = STOP;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = IDX_ZERO;
      end
    endcase

    case (state_nxt)
      IDLE:    tx_nxt = STOP_BIT;
      START:   tx_nxt = START_BIT;
      DATA:    tx_nxt = data_r[idx_nxt];
      PARITY:  tx_nxt = par_bit_r;
      STOP:    tx_nxt = STOP_BIT;
      default: tx_nxt = STOP_BIT;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // FSM state, bit index and the registered line/busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
      tx_r    <= STOP_BIT;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      idx_r   <= idx_nxt;
      tx_r    <= tx_nxt;
      busy_r  <= busy_nxt;
    end
  end

  // Frame settings captured on accept so later input changes cannot disturb the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= {DATA_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      prescale_r <= {PRESCALE_WIDTH{1'b0}};
    end else if (accept_s) begin
      data_r     <= P_DATA;
      par_en_r   <= PAR_EN;
      par_bit_r  <= parity_bit(P_DATA, PAR_TYP);
      prescale_r <= prescale;
    end else begin
      data_r     <= data_r;
      par_en_r   <= par_en_r;
      par_bit_r  <= par_bit_r;
      prescale_r <= prescale_r;
    end
  end

  assign TX_OUT = tx_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue of expected frames is filled on accept and a
// line monitor decodes TX_OUT slot by slot against the head of that queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    int         p;
    logic       b2b;
  } frame_t;

  frame_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_end = -100;

  uart_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .prescale  (prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Follows one frame from its start clock; gives up quietly if reset hits mid-frame
  task automatic check_frame(output logic aborted);
    frame_t     f;
    logic [10:0] bits;
    logic [7:0]  dec;
    int          nslots;
    int          good;
    aborted = 1'b0;
    dec     = 8'h00;
    if (exp_q.size() == 0) begin
      check_value("unexpected_start", 32'(exp_q.size()), 32'd1);
      return;
    end
    f = exp_q.pop_front();
    if (f.b2b) check_value("b2b_gap", 32'(cyc - last_end), 32'd1);
    bits      = 11'h7FF;
    bits[0]   = 1'b0;
    bits[8:1] = f.data;
    if (f.pe) bits[9] = f.pt ? ~^f.data : ^f.data;
    nslots = f.pe ? 11 : 10;
    for (int s = 0; s < nslots && !aborted; s++) begin
      good = 0;
      for (int c = 0; c < f.p && !aborted; c++) begin
        if (s != 0 || c != 0) begin
          @(posedge clk);
          #1;
        end
        if (!rst_n) begin
          aborted = 1'b1;
        end else begin
          if (TX_OUT === bits[s] && busy === 1'b1) good++;
          if (s >= 1 && s <= 8 && c == f.p / 2) dec[s-1] = TX_OUT;
        end
      end
      if (!aborted) check_value($sformatf("slot%0d_good_clks", s), 32'(good), 32'(f.p));
    end
    if (!aborted) begin
      check_value("rx_data", 32'(dec), 32'(f.data));
      @(posedge clk);
      #1;
      check_value("end_tx", 32'(TX_OUT), 32'd1);
      check_value("end_busy", 32'(busy), 32'd0);
      last_end = cyc;
    end
  endtask

  initial begin : monitor
    logic prev_tx;
    logic ab;
    prev_tx = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_tx = 1'b1;
      end else if (prev_tx === 1'b1 && TX_OUT === 1'b0) begin
        check_frame(ab);
        prev_tx = ab ? 1'b1 : TX_OUT;
      end else begin
        prev_tx = TX_OUT;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_value("idle_wait", 32'(t < 3000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    frame_t f;
    wait_idle();
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = ps;
    DATA_VALID = 1'b1;
    f = '{data: d, pe: pe, pt: pt, p: (ps == 6'd0) ? 1 : int'(ps), b2b: 1'b0};
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    DATA_VALID = 1'b0;
    P_DATA     = 8'($urandom);
    PAR_EN     = 1'($urandom);
    PAR_TYP    = 1'($urandom);
    prescale   = 6'($urandom);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t;
    rst_n      = 1'b0;
    DATA_VALID = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_tx", 32'(TX_OUT), 32'd1);
    check_value("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reference byte with odd, even and no parity
    send(8'h09, 1'b1, 1'b1, 6'd8);
    send(8'h09, 1'b1, 1'b0, 6'd8);
    send(8'h09, 1'b0, 1'b0, 6'd8);

    // DATA_VALID held across two frames
    wait_idle();
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescale   = 6'd4;
    DATA_VALID = 1'b1;
    exp_q.push_back('{data: 8'hA5, pe: 1'b0, pt: 1'b0, p: 4, b2b: 1'b0});
    @(posedge clk);
    #1;
    P_DATA = 8'h3C;
    exp_q.push_back('{data: 8'h3C, pe: 1'b0, pt: 1'b0, p: 4, b2b: 1'b1});
    t = 0;
    while (busy !== 1'b0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_value("b2b_first_end", 32'(t < 1000), 32'd1);
    @(posedge clk);
    #1;
    DATA_VALID = 1'b0;
    check_value("b2b_second_busy", 32'(busy), 32'd1);

    // Request while busy must be dropped
    send(8'h5A, 1'b1, 1'b0, 6'd8);
    repeat (20) @(negedge clk);
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    prescale   = 6'd1;
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;

    // Reset in the middle of data bit 4, then a clean frame
    send(8'hC3, 1'b1, 1'b1, 6'd8);
    repeat (42) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("midrst_tx", 32'(TX_OUT), 32'd1);
    check_value("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h6E, 1'b1, 1'b0, 6'd8);

    // All parity settings at two prescales, plus the 1 and 0 prescale boundary
    for (int k = 0; k < 8; k++) begin
      send(8'($urandom), 1'(k), 1'(k >> 1), (k < 4) ? 6'd8 : 6'd16);
    end
    send(8'h81, 1'b1, 1'b1, 6'd1);
    send(8'h7E, 1'b0, 1'b0, 6'd0);

    wait_idle();
    repeat (4) @(negedge clk);
    check_value("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
